// File: rtl/ram_arb_pkg.sv
// Shared types for the SDRAM port arbiter: FSM states, requester IDs and
// the round-robin successor helper.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RD,
        RECOVER
    } arb_state_e;

    typedef enum logic [1:0] {
        PORT_LD  = 2'd0,
        PORT_AU  = 2'd1,
        PORT_CPU = 2'd2
    } port_id_e;

    localparam int unsigned NUM_PORTS = 3;

    // Next port in round-robin order; wraps 2 -> 0 (3 is never a valid ID).
    function automatic logic [1:0] rr_next(input logic [1:0] p);
        return (p >= 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational 3-way round-robin picker with an optional fixed top
// priority for the audio port.
module rr_priority_pick
    import ram_arb_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [1:0]           rr_last_i,
    input  logic                 audio_prio_i,
    output logic                 grant_valid_o,
    output logic [1:0]           grant_id_o
);

    logic [1:0] idx;

    always_comb begin
        grant_valid_o = 1'b0;
        grant_id_o    = PORT_LD;
        idx           = rr_last_i;
        if (audio_prio_i && req_i[PORT_AU]) begin
            grant_valid_o = 1'b1;
            grant_id_o    = PORT_AU;
        end else begin
            // With priority on, audio is not requesting here, so it drops out naturally.
            for (int k = 0; k < int'(NUM_PORTS); k++) begin
                idx = rr_next(idx);
                if (!grant_valid_o && req_i[idx]) begin
                    grant_valid_o = 1'b1;
                    grant_id_o    = idx;
                end
            end
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one SDRAM word port between loader, audio and CPU requesters with a
// single outstanding operation and read data routed back to its owner.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 25,
    parameter int unsigned DATA_W     = 16,
    parameter logic [15:0] RD_TIMEOUT = 16'd1023,
    parameter logic        AUDIO_PRIO = 1'b1
) (
    input  logic              clk50,
    input  logic              reset_n,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_ack,
    input  logic              au_req,
    input  logic [ADDR_W-1:0] au_addr,
    output logic              au_ack,
    output logic [DATA_W-1:0] au_rdata,
    output logic              au_rvalid,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    output logic              ram_req,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    input  logic              ram_op_begun,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_rdata_valid,
    output logic              rd_timeout_err,
    output logic              busy
);

    arb_state_e        state_q;
    logic [1:0]        owner_q;
    logic [1:0]        rr_last_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] au_rdata_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic              au_rvalid_q;
    logic              cpu_rvalid_q;
    logic              err_q;
    logic [15:0]       cnt_q;

    logic              grant_valid;
    logic [1:0]        grant_id;
    logic              op_accept;

    rr_priority_pick u_pick (
        .req_i         ({cpu_req, au_req, ld_we}),
        .rr_last_i     (rr_last_q),
        .audio_prio_i  (AUDIO_PRIO),
        .grant_valid_o (grant_valid),
        .grant_id_o    (grant_id)
    );

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            owner_q      <= PORT_LD;
            rr_last_q    <= PORT_CPU;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            au_rdata_q   <= '0;
            cpu_rdata_q  <= '0;
            au_rvalid_q  <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            au_rvalid_q  <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (grant_valid) begin
                        owner_q <= grant_id;
                        state_q <= ISSUE;
                        // Fixed-priority audio grants leave the rotation untouched.
                        if (!(AUDIO_PRIO && grant_id == PORT_AU)) rr_last_q <= grant_id;
                        case (grant_id)
                            PORT_AU: begin
                                we_q    <= 1'b0;
                                addr_q  <= au_addr;
                                wdata_q <= '0;
                            end
                            PORT_CPU: begin
                                we_q    <= cpu_we;
                                addr_q  <= cpu_addr;
                                wdata_q <= cpu_wdata;
                            end
                            default: begin
                                we_q    <= 1'b1;
                                addr_q  <= ld_addr;
                                wdata_q <= ld_wdata;
                            end
                        endcase
                    end
                end
                ISSUE: begin
                    if (ram_op_begun) begin
                        if (we_q) begin
                            state_q <= RECOVER;
                        end else begin
                            cnt_q   <= '0;
                            state_q <= WAIT_RD;
                        end
                    end
                end
                WAIT_RD: begin
                    if (ram_rdata_valid) begin
                        if (owner_q == PORT_AU) begin
                            au_rdata_q  <= ram_rdata;
                            au_rvalid_q <= 1'b1;
                        end else begin
                            cpu_rdata_q  <= ram_rdata;
                            cpu_rvalid_q <= 1'b1;
                        end
                        state_q <= IDLE;
                    end else if (cnt_q == RD_TIMEOUT) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                RECOVER: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ram_req        = (state_q == ISSUE);
    assign ram_we         = ram_req & we_q;
    assign ram_address    = addr_q;
    assign ram_data       = wdata_q;
    assign op_accept      = ram_req & ram_op_begun;
    assign ld_ack         = op_accept & (owner_q == PORT_LD);
    assign au_ack         = op_accept & (owner_q == PORT_AU);
    assign cpu_ack        = op_accept & (owner_q == PORT_CPU);
    assign au_rdata       = au_rdata_q;
    assign au_rvalid      = au_rvalid_q;
    assign cpu_rdata      = cpu_rdata_q;
    assign cpu_rvalid     = cpu_rvalid_q;
    assign rd_timeout_err = err_q;
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: a table of single transactions plus
// hand-written multi-cycle sequences.
module tb_ram_port_arbiter;

    logic        clk50;
    logic        reset_n;
    logic        ld_we;
    logic [24:0] ld_addr;
    logic [15:0] ld_wdata;
    logic        ld_ack;
    logic        au_req;
    logic [24:0] au_addr;
    logic        au_ack;
    logic [15:0] au_rdata;
    logic        au_rvalid;
    logic        cpu_req;
    logic        cpu_we;
    logic [24:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_ack;
    logic [15:0] cpu_rdata;
    logic        cpu_rvalid;
    logic        ram_req;
    logic        ram_we;
    logic [24:0] ram_address;
    logic [15:0] ram_data;
    logic        ram_op_begun;
    logic        man_begun;
    logic        auto_begun;
    logic [15:0] ram_rdata;
    logic        ram_rdata_valid;
    logic        rd_timeout_err;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    int ld_ack_cnt = 0;
    int au_rv_cnt = 0;
    int cpu_rv_cnt = 0;
    logic [15:0] exp_au_rd;
    logic [15:0] exp_cpu_rd;

    typedef struct {
        logic        ld;
        logic        au;
        logic        cpu;
        logic        cpu_we;
        logic [2:0]  exp_ack;   // {cpu, au, ld}
        logic        exp_we;
        logic [24:0] exp_addr;
        logic [15:0] exp_wdata;
        logic [15:0] rdata;
    } vec_t;

    vec_t vecs[9];

    assign ram_op_begun = man_begun | (auto_begun & ram_req);

    ram_port_arbiter #(
        .ADDR_W     (25),
        .DATA_W     (16),
        .RD_TIMEOUT (16'd1023),
        .AUDIO_PRIO (1'b1)
    ) dut (
        .clk50           (clk50),
        .reset_n         (reset_n),
        .ld_we           (ld_we),
        .ld_addr         (ld_addr),
        .ld_wdata        (ld_wdata),
        .ld_ack          (ld_ack),
        .au_req          (au_req),
        .au_addr         (au_addr),
        .au_ack          (au_ack),
        .au_rdata        (au_rdata),
        .au_rvalid       (au_rvalid),
        .cpu_req         (cpu_req),
        .cpu_we          (cpu_we),
        .cpu_addr        (cpu_addr),
        .cpu_wdata       (cpu_wdata),
        .cpu_ack         (cpu_ack),
        .cpu_rdata       (cpu_rdata),
        .cpu_rvalid      (cpu_rvalid),
        .ram_req         (ram_req),
        .ram_we          (ram_we),
        .ram_address     (ram_address),
        .ram_data        (ram_data),
        .ram_op_begun    (ram_op_begun),
        .ram_rdata       (ram_rdata),
        .ram_rdata_valid (ram_rdata_valid),
        .rd_timeout_err  (rd_timeout_err),
        .busy            (busy)
    );

    initial clk50 = 1'b0;
    always #10 clk50 = ~clk50;

    always @(posedge clk50) begin
        if (ld_ack) ld_ack_cnt <= ld_ack_cnt + 1;
        if (au_rvalid) au_rv_cnt <= au_rv_cnt + 1;
        if (cpu_rvalid) cpu_rv_cnt <= cpu_rv_cnt + 1;
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc();
        @(posedge clk50);
        #2;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_req(input string name);
        int n;
        n = 0;
        while (!ram_req && n < 20) begin
            cyc();
            n++;
        end
        check(name, ram_req, 1);
    endtask

    // One transaction from IDLE: grant, immediate op_begun, optional read data.
    task automatic run_vec(input vec_t v, input int idx);
        ld_we = v.ld; au_req = v.au; cpu_req = v.cpu; cpu_we = v.cpu_we;
        cyc();
        check($sformatf("v%0d_ram_req", idx), ram_req, 1);
        check($sformatf("v%0d_ram_we", idx), ram_we, v.exp_we);
        check($sformatf("v%0d_addr", idx), ram_address, v.exp_addr);
        if (v.exp_we) check($sformatf("v%0d_data", idx), ram_data, v.exp_wdata);
        man_begun = 1'b1;
        #1;
        check($sformatf("v%0d_ack", idx), {cpu_ack, au_ack, ld_ack}, v.exp_ack);
        cyc();
        man_begun = 1'b0;
        ld_we = 1'b0; au_req = 1'b0; cpu_req = 1'b0;
        check($sformatf("v%0d_ack_done", idx), {cpu_ack, au_ack, ld_ack}, 0);
        if (!v.exp_we) begin
            ram_rdata = v.rdata;
            ram_rdata_valid = 1'b1;
            cyc();
            ram_rdata_valid = 1'b0;
            if (v.exp_ack[1]) exp_au_rd = v.rdata;
            else exp_cpu_rd = v.rdata;
            check($sformatf("v%0d_rvalid", idx), {cpu_rvalid, au_rvalid}, v.exp_ack[2:1]);
            check($sformatf("v%0d_au_rdata", idx), au_rdata, exp_au_rd);
            check($sformatf("v%0d_cpu_rdata", idx), cpu_rdata, exp_cpu_rd);
        end
        cyc();
        check($sformatf("v%0d_rvalid_clr", idx), {cpu_rvalid, au_rvalid}, 0);
        check($sformatf("v%0d_idle", idx), busy, 0);
    endtask

    initial begin
        int base;
        int n;
        int gid[$];
        int gcyc[$];
        logic done;
        vec_t fv;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 25'h00000AA, 16'h1111, 16'h0000};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'b100, 1'b0, 25'h00000CC, 16'h0000, 16'hC0DE};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'b010, 1'b0, 25'h00000BB, 16'h0000, 16'h1234};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 3'b001, 1'b1, 25'h00000AA, 16'h1111, 16'h0000};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 3'b100, 1'b1, 25'h00000CC, 16'h2222, 16'h0000};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 3'b010, 1'b0, 25'h00000BB, 16'h0000, 16'h5A5A};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 3'b001, 1'b1, 25'h00000AA, 16'h1111, 16'h0000};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 1'b0, 25'h00000BB, 16'h0000, 16'h0F0F};
        vecs[8] = '{1'b1, 1'b0, 1'b1, 1'b1, 3'b100, 1'b1, 25'h00000CC, 16'h2222, 16'h0000};

        reset_n = 1'b0;
        ld_we = 0; au_req = 0; cpu_req = 0; cpu_we = 0;
        ld_addr = 25'h00000AA; ld_wdata = 16'h1111;
        au_addr = 25'h00000BB;
        cpu_addr = 25'h00000CC; cpu_wdata = 16'h2222;
        man_begun = 0; auto_begun = 0; ram_rdata = 0; ram_rdata_valid = 0;
        exp_au_rd = 0; exp_cpu_rd = 0;

        #25;
        check("reset_outputs", {ram_req, ram_we, ram_address, ram_data, ld_ack, au_ack, cpu_ack,
                                au_rvalid, cpu_rvalid, rd_timeout_err, busy}, 0);
        check("reset_rdata", {au_rdata, cpu_rdata}, 0);
        #10 reset_n = 1'b1;
        cyc();
        check("idle_after_reset", busy, 0);

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // Loader streams four words; op_begun comes two cycles after ram_req.
        base = ld_ack_cnt;
        for (int w = 0; w < 4; w++) begin
            ld_addr = 25'(w); ld_wdata = 16'hA5A0 + 16'(w); ld_we = 1'b1;
            wait_req("stream_req");
            check("stream_addr", ram_address, 25'(w));
            check("stream_data", ram_data, 16'hA5A0 + 16'(w));
            check("stream_we", ram_we, 1);
            cyc();
            cyc();
            check("stream_hold_addr", ram_address, 25'(w));
            check("stream_no_early_ack", ld_ack, 0);
            man_begun = 1'b1;
            #1;
            check("stream_ack", ld_ack, 1);
            cyc();
            man_begun = 1'b0;
            // Request lingers through the recovery cycle; must not be regranted.
            cyc();
            ld_we = 1'b0;
            cyc();
            check("stream_no_regrant", busy, 0);
        end
        check("stream_ack_count", ld_ack_cnt - base, 4);

        // Spurious controller strobes outside their states.
        man_begun = 1'b1;
        #1;
        check("spur_begun_ack", {cpu_ack, au_ack, ld_ack}, 0);
        cyc();
        man_begun = 1'b0;
        check("spur_begun_busy", busy, 0);
        cpu_addr = 25'h00000CC; cpu_we = 1'b0; cpu_req = 1'b1;
        cyc();
        check("spur_issue", ram_req, 1);
        ram_rdata = 16'hDEAD; ram_rdata_valid = 1'b1;
        cyc();
        ram_rdata_valid = 1'b0;
        check("spur_valid_rvalid", cpu_rvalid, 0);
        check("spur_valid_still_issue", ram_req, 1);
        check("spur_valid_rdata", cpu_rdata, exp_cpu_rd);
        man_begun = 1'b1;
        #1;
        check("spur_cpu_ack", cpu_ack, 1);
        cyc();
        man_begun = 1'b0; cpu_req = 1'b0;
        ram_rdata = 16'h7777; ram_rdata_valid = 1'b1;
        cyc();
        ram_rdata_valid = 1'b0;
        exp_cpu_rd = 16'h7777;
        check("spur_read_rvalid", cpu_rvalid, 1);
        check("spur_read_rdata", cpu_rdata, exp_cpu_rd);
        cyc();

        // Read timeout: data never arrives.
        base = cpu_rv_cnt;
        cpu_addr = 25'h1FFFFFF; cpu_we = 1'b0; cpu_req = 1'b1;
        cyc();
        check("to_addr", ram_address, 25'h1FFFFFF);
        man_begun = 1'b1;
        #1;
        check("to_ack", cpu_ack, 1);
        done = 1'b0;
        n = 0;
        for (int k = 1; k <= 1100; k++) begin
            cyc();
            man_begun = 1'b0; cpu_req = 1'b0;
            if (!busy) begin
                n = k;
                done = 1'b1;
                break;
            end
            if (k == 1000) check("to_err_not_early", rd_timeout_err, 0);
        end
        check("to_returned_idle", done, 1);
        check("to_cycles", n, 1025);
        check("to_err_set", rd_timeout_err, 1);
        check("to_no_rvalid", cpu_rv_cnt - base, 0);
        ld_addr = 25'h00000AA; ld_wdata = 16'h1111;
        fv = vecs[0];
        run_vec(fv, 100);
        check("to_err_sticky", rd_timeout_err, 1);

        // Asynchronous reset in the middle of a read.
        base = cpu_rv_cnt;
        cpu_addr = 25'h0ABCDE; cpu_we = 1'b0; cpu_req = 1'b1;
        cyc();
        man_begun = 1'b1;
        cyc();
        man_begun = 1'b0; cpu_req = 1'b0;
        cyc();
        check("rst_in_wait", {busy, ram_req}, 2'b10);
        #3;
        reset_n = 1'b0;
        #1;
        check("rst_async_outputs", {ram_req, ram_we, ram_address, ram_data, ld_ack, au_ack, cpu_ack,
                                    au_rvalid, cpu_rvalid, rd_timeout_err, busy}, 0);
        check("rst_async_rdata", {au_rdata, cpu_rdata}, 0);
        #5;
        reset_n = 1'b1;
        cyc();
        ram_rdata = 16'hBEEF; ram_rdata_valid = 1'b1;
        cyc();
        ram_rdata_valid = 1'b0;
        cyc();
        check("rst_late_valid_ignored", cpu_rv_cnt - base, 0);
        check("rst_late_rdata", cpu_rdata, 0);
        check("rst_late_idle", busy, 0);

        // Loader and CPU writes held continuously: strict alternation, 3-cycle writes.
        cpu_we = 1'b1; cpu_req = 1'b1; ld_we = 1'b1; auto_begun = 1'b1;
        for (int k = 0; k < 30; k++) begin
            cyc();
            if (ld_ack) begin gid.push_back(0); gcyc.push_back(k); end
            if (cpu_ack) begin gid.push_back(2); gcyc.push_back(k); end
        end
        cpu_req = 1'b0; ld_we = 1'b0; auto_begun = 1'b0;
        check("alt_grant_count_ge4", gid.size() >= 4, 1);
        if (gid.size() >= 4) begin
            check("alt_g0", gid[0], 0);
            check("alt_g1", gid[1], 2);
            check("alt_g2", gid[2], 0);
            check("alt_g3", gid[3], 2);
            check("alt_first_cycle", gcyc[0], 0);
            check("alt_gap1", gcyc[1] - gcyc[0], 3);
            check("alt_gap3", gcyc[3] - gcyc[2], 3);
        end
        cyc();
        cyc();
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single 32Mx16 SDRAM word port between three requesters:
  - port 0: SD-card loader, write-only, level-held request until op_begun;
  - port 1: MP3 audio fetch, read-only, real-time;
  - port 2: CPU/debug, read or write.
- Sits between the requesters and the SDRAM controller.
- Sequences exactly one outstanding RAM operation at a time and routes read data back to its owner.

Parameters:
- ADDR_W, 25, word address width.
- DATA_W, 16, data width.
- RD_TIMEOUT, 16'd1023, max cycles to wait for ram_rdata_valid after op_begun.
- AUDIO_PRIO, 1'b1, 1 = port 1 has fixed top priority; 0 = port 1 joins round-robin.

Ports:
- clk50 in 1: system clock.
- reset_n in 1: asynchronous, active-low reset.
- ld_we in 1: loader write request, held until ld_ack.
- ld_addr in ADDR_W: loader address.
- ld_wdata in DATA_W: loader write data.
- ld_ack out 1: one-cycle op_begun pulse to loader.
- au_req in 1: audio read request, held until au_ack.
- au_addr in ADDR_W: audio address.
- au_ack out 1: one-cycle accept pulse.
- au_rdata out DATA_W: read data.
- au_rvalid out 1: one-cycle read data valid.
- cpu_req in 1: CPU request, held until cpu_ack.
- cpu_we in 1: 1 = write, 0 = read.
- cpu_addr in ADDR_W: CPU address.
- cpu_wdata in DATA_W: CPU write data.
- cpu_ack out 1: one-cycle accept pulse.
- cpu_rdata out DATA_W: read data.
- cpu_rvalid out 1: one-cycle read data valid.
- ram_req out 1: request to SDRAM controller.
- ram_we out 1: write enable qualifying ram_req.
- ram_address out ADDR_W: address to SDRAM controller.
- ram_data out DATA_W: write data to SDRAM controller.
- ram_op_begun in 1: controller accepted current op.
- ram_rdata in DATA_W: read data from controller.
- ram_rdata_valid in 1: read data strobe.
- rd_timeout_err out 1: sticky, set on read timeout.
- busy out 1: high when state != IDLE.

Behaviour:
- Reset (reset_n low, async):
  - state = IDLE; owner = 0; rr_last = 2; timeout counter = 0.
  - All outputs 0, including ram_address, ram_data, au_rdata, cpu_rdata and rd_timeout_err.
- States: IDLE, ISSUE, WAIT_RD, RECOVER.
- IDLE: sample requests (ld_we, au_req, cpu_req).
  - AUDIO_PRIO = 1: au_req wins whenever asserted.
  - Among remaining ports, round-robin starting after rr_last.
  - On a grant: register owner, we, address and wdata from the winning port (snapshot); update rr_last only on round-robin grants; go to ISSUE.
  - No request: stay in IDLE.
  - Grant decision takes 1 cycle, so ram_req asserts the cycle after a request is first seen.
- ISSUE: ram_req = 1; ram_we, ram_address and ram_data come from the snapshot registers.
  - On ram_op_begun: pulse the owner's ack for exactly 1 cycle (the same cycle as op_begun, combinational from op_begun & owner).
  - Write: go to RECOVER.
  - Read: clear the timeout counter and go to WAIT_RD.
  - Without op_begun: remain in ISSUE indefinitely; snapshot is stable.
- WAIT_RD: ram_req = 0.
  - On ram_rdata_valid: register ram_rdata into the owner's rdata; pulse the owner's rvalid for 1 cycle (registered, i.e. the cycle after ram_rdata_valid); go to IDLE.
  - Counter reaches RD_TIMEOUT: set rd_timeout_err (sticky until reset); no rvalid pulse; go to IDLE.
- RECOVER: one idle cycle, then go to IDLE.
  - Guarantees a requester's request, dropped the cycle after its ack, is not regranted twice.
- Non-owner rdata registers hold their previous value.
- ram_rdata_valid outside WAIT_RD is ignored.
- ram_op_begun outside ISSUE is ignored; no ack is generated.
- A request deasserted before ack (protocol violation) does not cancel an op already in ISSUE; the op completes and the ack is still pulsed.
- Simultaneous requests from all three ports with AUDIO_PRIO = 1: audio first, then loader/CPU alternate.
- Throughput:
  - Write: 3 cycles minimum (IDLE, ISSUE with immediate op_begun, RECOVER).
  - Read: IDLE + ISSUE + data latency + 1.
- rr_last is 2 bits; round-robin wraps 2 -> 0.

Decomposition:
- Shared package ram_arb_pkg:
  - typedef enum of states {IDLE, ISSUE, WAIT_RD, RECOVER};
  - typedef enum of port IDs {PORT_LD = 0, PORT_AU = 1, PORT_CPU = 2};
  - a port-count constant.
- One natural sub-module: rr_priority_pick.
  - Combinational 3-way round-robin with optional fixed-priority override.
  - Inputs: req vector, rr_last, AUDIO_PRIO.
  - Outputs: grant_valid, grant_id.

Test Plan:
- Loader streams 4 writes (addr 0..3, data 16'hA5A0..A5A3), op_begun 2 cycles after ram_req -> four ld_ack pulses; ram_address/ram_data match each word; never two acks for one word.
- au_req and ld_we asserted together, AUDIO_PRIO = 1 -> audio granted first; after read data 16'h1234, au_rvalid pulses once with au_rdata = 16'h1234; loader granted next.
- Loader and CPU (write) held continuously, no audio -> grants alternate LD, CPU, LD, CPU starting with port 0 after reset.
- CPU read at addr 25'h1FFFFFF, ram_rdata_valid withheld -> after RD_TIMEOUT cycles rd_timeout_err = 1, no cpu_rvalid, state back to IDLE; the next request is served normally and the error stays set.
- reset_n pulsed low mid-WAIT_RD -> all outputs 0 immediately (async); a late ram_rdata_valid is ignored; no rvalid pulse.
- Spurious ram_op_begun in IDLE and ram_rdata_valid in ISSUE -> no ack and no rvalid pulses.
